// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency 64-bit doubleword load/store responder for the MEM stage.
//   CLK, resetl (async, active-low)
//   MemoryRead/MemoryWrite/Address/WriteData : request, sampled only in IDLE
//   ReadData : load data, valid while done=1
//   busy     : combinational stall request (IDLE with request, or WAIT)
//   done     : one-cycle response marker; fault qualifies it (access rejected)
module dmem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData,
  output logic        busy,
  output logic        done,
  output logic        fault
);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [63:0] addr_q, wdata_q;
  logic rd_q, wr_q;
  // Aligned-only access lets the byte store be kept as little-endian doublewords.
  logic [63:0] mem [2**(ADDR_BITS-3)];
  logic req, fire, bad, c_rd, c_wr;
  logic [63:0] c_addr, c_wdata;
  logic [ADDR_BITS-4:0] idx;
  assign req = MemoryRead | MemoryWrite;
  // With LATENCY=1 the access happens on the accept edge, so the live inputs act as the capture.
  assign c_addr = state == IDLE ? Address : addr_q;
  assign c_wdata = state == IDLE ? WriteData : wdata_q;
  assign c_rd = state == IDLE ? MemoryRead : rd_q;
  assign c_wr = state == IDLE ? MemoryWrite : wr_q;
  assign bad = (|c_addr[2:0]) | (|c_addr[63:ADDR_BITS]) | (c_rd & c_wr);
  assign idx = c_addr[ADDR_BITS-1:3];
  assign fire = state_nx == RESP;
  assign busy = (state == IDLE & req) | state == WAIT;
  assign done = state == RESP;
  always_comb begin
    state_nx = state;
    state_nx = state == RESP ? IDLE :
               state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
               !req ? IDLE : LATENCY == 1 ? RESP : WAIT;
  end
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ReadData <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        addr_q <= Address;
        wdata_q <= WriteData;
        rd_q <= MemoryRead;
        wr_q <= MemoryWrite;
        cnt <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      fault <= fire & bad;
      if (fire && bad) ReadData <= '0;
      else if (fire && c_rd) ReadData <= mem[idx];
    end
  end
  // Gated by resetl so an access aborted by reset never commits its write.
  always_ff @(posedge CLK) begin
    if (resetl && fire && c_wr && !bad) mem[idx] <= c_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed check of dmem_responder at LATENCY 1, 2 and 4.
module tb_dmem_responder;
  localparam int AB = 10;
  logic clk = 1'b0;
  logic rstn [3];
  logic mr [3];
  logic mw [3];
  logic [63:0] ad [3];
  logic [63:0] wd [3];
  logic [63:0] rdat [3];
  logic bsy [3];
  logic dn [3];
  logic flt [3];
  logic e_busy [3];
  logic e_done [3];
  logic e_fault [3];
  logic [63:0] e_rd [3];
  logic [63:0] seen_rd [3];
  logic seen_flt [3];
  logic [7:0] mem_m [3][1024];
  logic run = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.ADDR_BITS(AB), .LATENCY(g == 0 ? 1 : g == 1 ? 2 : 4)) dut (
      .CLK(clk),
      .resetl(rstn[g]),
      .MemoryRead(mr[g]),
      .MemoryWrite(mw[g]),
      .Address(ad[g]),
      .WriteData(wd[g]),
      .ReadData(rdat[g]),
      .busy(bsy[g]),
      .done(dn[g]),
      .fault(flt[g])
    );
  end
  task automatic chk(string name, int k, logic [63:0] got, logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, k, got, want, $time);
  endtask
  function automatic int lat_of(int k);
    return k == 0 ? 1 : k == 1 ? 2 : 4;
  endfunction
  function automatic logic is_fault(logic r, logic w, logic [63:0] a);
    return (a % 8 != 0) || (a >= 64'(1 << AB)) || (r && w);
  endfunction
  function automatic logic [63:0] mread(int k, logic [63:0] a);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = v | (64'(mem_m[k][int'(a) + i]) << (8 * i));
    return v;
  endfunction
  task automatic mwrite(int k, logic [63:0] a, logic [63:0] d);
    for (int i = 0; i < 8; i++) mem_m[k][int'(a) + i] = d[8*i +: 8];
  endtask
  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 3; k++) begin
        chk("busy", k, 64'(bsy[k]), 64'(e_busy[k]));
        chk("done", k, 64'(dn[k]), 64'(e_done[k]));
        chk("fault", k, 64'(flt[k]), 64'(e_fault[k]));
        chk("rdata", k, rdat[k], e_rd[k]);
        if (dn[k] === 1'b1) begin
          seen_rd[k] = rdat[k];
          seen_flt[k] = flt[k];
        end
      end
    end
  end
  // Presents a request in an IDLE cycle and walks the expected timeline to the next IDLE cycle.
  task automatic access(int k, logic r, logic w, logic [63:0] a, logic [63:0] d, logic scramble);
    int lat = lat_of(k);
    logic f = is_fault(r, w, a);
    mr[k] = r;
    mw[k] = w;
    ad[k] = a;
    wd[k] = d;
    e_busy[k] = 1'b1;
    e_done[k] = 1'b0;
    e_fault[k] = 1'b0;
    for (int j = 1; j < lat; j++) begin
      @(posedge clk); #1;
      if (scramble) begin
        ad[k] = {$urandom, $urandom};
        wd[k] = {$urandom, $urandom};
      end
    end
    @(posedge clk); #1;
    mr[k] = 1'b0;
    mw[k] = 1'b0;
    e_busy[k] = 1'b0;
    e_done[k] = 1'b1;
    e_fault[k] = f;
    if (f) e_rd[k] = '0;
    else begin
      if (r) e_rd[k] = mread(k, a);
      if (w) mwrite(k, a, d);
    end
    @(posedge clk); #1;
    e_done[k] = 1'b0;
    e_fault[k] = 1'b0;
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0;
      mr[k] = 1'b0;
      mw[k] = 1'b0;
      ad[k] = '0;
      wd[k] = '0;
      e_busy[k] = 1'b0;
      e_done[k] = 1'b0;
      e_fault[k] = 1'b0;
      e_rd[k] = '0;
      seen_rd[k] = '0;
      seen_flt[k] = 1'b0;
      for (int i = 0; i < 1024; i++) mem_m[k][i] = 8'h00;
    end
    // Reset held with a read pending: busy follows the request, everything else cleared.
    mr[1] = 1'b1;
    ad[1] = 64'h40;
    e_busy[1] = 1'b1;
    run = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rstn[k] = 1'b1;
    access(1, 1, 0, 64'h40, 0, 0);
    chk("lit_first_read", 1, seen_rd[1], 64'h0);
    access(1, 0, 1, 64'h40, 64'h1122334455667788, 0);
    chk("lit_wr_fault", 1, 64'(seen_flt[1]), 64'h0);
    access(1, 1, 0, 64'h40, 0, 0);
    chk("lit_rd40", 1, seen_rd[1], 64'h1122334455667788);
    chk("lit_byte40", 1, 64'(seen_rd[1][7:0]), 64'h88);
    chk("lit_model_byte40", 1, 64'(mem_m[1][64]), 64'h88);
    access(1, 1, 0, 64'h44, 0, 0);
    chk("lit_misalign_flt", 1, 64'(seen_flt[1]), 64'h1);
    chk("lit_misalign_rd", 1, seen_rd[1], 64'h0);
    access(1, 1, 0, 64'h400, 0, 0);
    chk("lit_range_flt", 1, 64'(seen_flt[1]), 64'h1);
    access(1, 1, 1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    chk("lit_both_flt", 1, 64'(seen_flt[1]), 64'h1);
    access(1, 1, 0, 64'h40, 0, 0);
    chk("lit_no_write", 1, seen_rd[1], 64'h1122334455667788);
    access(0, 0, 1, 64'h3F8, 64'hA5A5_0102_0304_0506, 0);
    access(0, 1, 0, 64'h3F8, 0, 0);
    chk("lit_top_dw", 0, seen_rd[0], 64'hA5A5_0102_0304_0506);
    access(2, 0, 1, 64'h20, 64'h5555, 1);
    access(2, 1, 0, 64'h20, 0, 1);
    chk("lit_scramble", 2, seen_rd[2], 64'h5555);
    // Reset in the second WAIT cycle of a write: aborted, nothing committed.
    mw[2] = 1'b1;
    ad[2] = 64'h80;
    wd[2] = 64'hDEAD;
    e_busy[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn[2] = 1'b0;
    mw[2] = 1'b0;
    e_busy[2] = 1'b0;
    e_rd[2] = '0;
    #1;
    chk("lit_rst_wait_rd", 2, rdat[2], 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    access(2, 1, 0, 64'h80, 0, 0);
    chk("lit_aborted_wr", 2, seen_rd[2], 64'h0);
    // Reset during RESP of a write: already committed, outputs clear at once.
    mw[1] = 1'b1;
    ad[1] = 64'h100;
    wd[1] = 64'hCAFE_F00D_1234_5678;
    e_busy[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mw[1] = 1'b0;
    e_busy[1] = 1'b0;
    e_done[1] = 1'b1;
    mwrite(1, 64'h100, 64'hCAFE_F00D_1234_5678);
    @(negedge clk); #1;
    rstn[1] = 1'b0;
    e_done[1] = 1'b0;
    e_rd[1] = '0;
    #1;
    chk("lit_rst_resp_done", 1, 64'(dn[1]), 64'h0);
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    access(1, 1, 0, 64'h100, 0, 0);
    chk("lit_committed", 1, seen_rd[1], 64'hCAFE_F00D_1234_5678);
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 150; n++) begin
        int sel = $urandom_range(0, 19);
        int op = $urandom_range(0, 9);
        logic [63:0] a;
        a = sel < 16 ? 64'($urandom_range(0, 15)) * 8 :
            sel < 18 ? 64'($urandom_range(0, 1023)) :
            sel < 19 ? 64'h3F8 : {$urandom, $urandom};
        access(k, op < 4 || op == 9 || op == 8, op >= 4 && op <= 8, a,
               {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          @(posedge clk); #1;
        end
      end
    end
    @(negedge clk);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
